// File: rtl/riscv_fetch_queue_pkg.sv
// Shared constants and entry layout for the instruction-fetch front end.
package riscv_fetch_queue_pkg;
    localparam int DEFAULT_XLEN = 32;
    localparam int INSTR_W = 32;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] addr;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_queue_if.sv
// Memory request/response, redirect and decode hand-off signals of the fetch front end.
interface riscv_fetch_queue_if
    import riscv_fetch_queue_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    instr_addr;
    logic [CW-1:0]      count;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_addr, count,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_addr, count,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/riscv_fetch_queue_fifo.sv
// Purpose: synchronous FIFO with flush, head output and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push into a full FIFO is honoured only alongside a pop; flush wins over both.
module riscv_fetch_queue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_vld,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign do_pop   = pop && head_vld;
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    // Empty head reads as zero so downstream never sees stale storage.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/riscv_fetch_queue.sv
// Purpose: PC generator plus prefetch queue; tags returned words with their fetch address.
// Latency: response to instr_valid in 1 cycle; redirect takes effect on the next edge.
// Backpressure: requests are credit-limited so responses always find a free slot.
module riscv_fetch_queue
    import riscv_fetch_queue_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input logic                 clk,
    input logic                 reset,
    riscv_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef struct packed {
        logic [XLEN-1:0]    addr;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count_q;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_keep;
    logic            head_vld;
    entry_t          push_entry;
    entry_t          head_entry;

    assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used     = {1'b0, count_q} + {1'b0, outstanding};

    // Every issued request reserves a queue slot until its response lands.
    assign bus.mem_req_valid = !reset && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp_keep          = bus.mem_rsp_valid && !bus.redirect_valid && (drop == '0);
    assign outstanding_nxt   = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
    assign push_entry        = '{addr: rsp_pc, instr: bus.mem_rsp_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect_valid) begin
                // Everything still in flight belongs to the abandoned path.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop     <= outstanding_nxt;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + STEP;
                if (rsp_keep) rsp_pc <= rsp_pc + STEP;
                if (bus.mem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    riscv_fetch_queue_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rsp_keep),
        .push_dat (push_entry),
        .pop      (bus.instr_valid && bus.instr_ready),
        .flush    (bus.redirect_valid),
        .head_vld (head_vld),
        .head_dat (head_entry),
        .count    (count_q)
    );

    assign bus.instr_valid = head_vld;
    assign bus.instr       = head_entry.instr;
    assign bus.instr_addr  = head_entry.addr;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Randomised fetch-queue bench: memory model and scoreboard predict the decode stream from PC rules.
module tb_riscv_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    riscv_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();
    riscv_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus2 ();

    riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    exp_t exp_q[$];
    req_t inflight[$];
    exp_t mon_e;
    logic [31:0] exp_fetch_pc;
    int epoch;
    int p_req_rdy = 100;
    int p_rsp = 100;
    int p_instr_rdy = 100;
    int p_redir = 0;
    bit stream_mode = 1'b0;
    bit mon_en = 1'b0;
    bit drv_en = 1'b0;
    int force_req = 0;
    int force_ack = 0;
    logic [31:0] force_pc = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: occupancy, credit rule and the head of the decode stream.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 32'(bus.count), 32'(exp_q.size()));
            check("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
            check("req_valid_credit", 32'(bus.mem_req_valid),
                  32'(!bus.redirect_valid && (exp_q.size() + inflight.size() < DEPTH)));
            if (stream_mode) check("stream_count_le2", 32'(bus.count <= 2), 32'd1);
            if (bus.instr_valid && bus.instr_ready && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("instr_addr", bus.instr_addr, mon_e.addr);
                check("instr_data", bus.instr, mon_e.data);
                pops++;
            end
        end
    end

    // Memory model and stimulus driver for the main instance.
    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        exp_fetch_pc       = 32'h0;
        epoch              = 0;
        wait (drv_en);
        forever begin
            bit acc;
            bit rsp_d;
            bit redir_d;
            logic [31:0] acc_addr;
            req_t r;
            exp_t ne;
            @(negedge clk);
            acc      = bus.mem_req_valid && bus.mem_req_ready;
            acc_addr = bus.mem_req_addr;
            rsp_d    = bus.mem_rsp_valid;
            redir_d  = bus.redirect_valid;
            if (acc) check("req_addr", acc_addr, exp_fetch_pc);
            @(posedge clk);
            #1;
            if (rsp_d) begin
                r = inflight.pop_front();
                if (!redir_d && r.epoch == epoch) begin
                    ne.addr = r.addr;
                    ne.data = word_of(r.addr);
                    exp_q.push_back(ne);
                end
            end
            if (acc) begin
                r.addr  = acc_addr;
                r.epoch = epoch;
                inflight.push_back(r);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (redir_d) begin
                epoch++;
                exp_q.delete();
                exp_fetch_pc = bus.redirect_pc & ~32'h3;
            end
            bus.mem_req_ready = roll(p_req_rdy);
            bus.instr_ready   = roll(p_instr_rdy);
            if (inflight.size() != 0 && roll(p_rsp)) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = word_of(inflight[0].addr);
            end else begin
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = $urandom;
            end
            if (force_req != force_ack) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = force_pc;
                force_ack          = force_req;
            end else if (roll(p_redir)) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
            end else begin
                bus.redirect_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] wrap_exp [3];
        logic [31:0] wrap_dat [3];
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) wrap_dat[i] = $urandom;

        rst  = 1'b1;
        rst2 = 1'b1;
        bus2.mem_req_ready  = 1'b0;
        bus2.mem_rsp_valid  = 1'b0;
        bus2.mem_rsp_data   = '0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.instr_ready    = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
            check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
            check("rst_count", 32'(bus.count), 32'd0);
            check("rst_instr", bus.instr, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("first_req_addr", bus.mem_req_addr, 32'h0);
        mon_en = 1'b1;
        drv_en = 1'b1;

        // Streaming with everything ready.
        stream_mode = 1'b1;
        repeat (40) @(posedge clk);
        stream_mode = 1'b0;

        // Decode stalls: queue fills to DEPTH and requests stop.
        p_instr_rdy = 0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("bp_count", 32'(bus.count), 32'(DEPTH));
        check("bp_req_valid", 32'(bus.mem_req_valid), 32'd0);
        p_instr_rdy = 100;
        repeat (20) @(posedge clk);

        // Redirect to an unaligned target while responses are held back.
        p_rsp = 0;
        repeat (3) @(posedge clk);
        force_pc = 32'h0000_0103;
        force_req++;
        repeat (3) @(posedge clk);
        p_rsp = 100;
        repeat (30) @(posedge clk);

        // Random traffic, then a redirect-heavy mix to hit rsp+pop+redirect together.
        p_req_rdy = 70; p_rsp = 60; p_instr_rdy = 60; p_redir = 4;
        repeat (3000) @(posedge clk);
        p_req_rdy = 90; p_rsp = 90; p_instr_rdy = 90; p_redir = 15;
        repeat (1500) @(posedge clk);
        p_req_rdy = 100; p_rsp = 100; p_instr_rdy = 100; p_redir = 0;
        repeat (40) @(posedge clk);
        check("pops_seen", 32'(pops > 500), 32'd1);

        // Second instance: PC wrap from the top of the address space.
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        bus2.mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrap_req_valid", 32'(bus2.mem_req_valid), 32'd1);
            check("wrap_req_addr", bus2.mem_req_addr, wrap_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus2.mem_req_ready = 1'b0;
            bus2.mem_rsp_valid = 1'b1;
            bus2.mem_rsp_data  = wrap_dat[i];
        end
        @(posedge clk);
        #1 bus2.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("wrap_count", 32'(bus2.count), 32'd3);
        check("wrap_instr_valid", 32'(bus2.instr_valid), 32'd1);
        check("wrap_instr_addr", bus2.instr_addr, wrap_exp[0]);
        check("wrap_instr", bus2.instr, wrap_dat[0]);

        // Asynchronous reset between clock edges clears outputs immediately.
        #2 rst2 = 1'b1;
        #1;
        check("arst_instr_valid", 32'(bus2.instr_valid), 32'd0);
        check("arst_count", 32'(bus2.count), 32'd0);
        check("arst_instr", bus2.instr, 32'd0);
        check("arst_instr_addr", bus2.instr_addr, 32'd0);
        check("arst_req_valid", 32'(bus2.mem_req_valid), 32'd0);
        check("arst_req_addr", bus2.mem_req_addr, 32'hFFFF_FFF8);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
